// File: rtl/trigger_dist_pkg.sv
// Shared types and widths for the trigger-distribution path.
package trigger_dist_pkg;

    localparam int unsigned c_trig_holdoff_width = 16;
    localparam int unsigned c_drop_cnt_width     = 16;
    localparam int unsigned c_trig_id_width      = 16;
    localparam int unsigned c_ch_idx_width       = 3;

    typedef struct packed {
        logic [39:0] tai;
        logic [27:0] cycles;
        logic [11:0] frac;
    } t_trig_ts;

    typedef struct packed {
        logic [c_trig_id_width-1:0] id;
        t_trig_ts                   ts;
    } t_trig_ev;

endpackage

// File: rtl/rr_arbiter_core.sv
// Round-robin priority search starting after the last grant, plus the pointer register.
module rr_arbiter_core #(
    parameter int unsigned g_num_req   = 4,
    parameter int unsigned g_idx_width = 3
) (
    input  logic                   clk_sys_i,
    input  logic                   rst_i,
    input  logic [g_num_req-1:0]   req_i,
    input  logic                   en_i,
    output logic [g_num_req-1:0]   gnt_o,
    output logic [g_idx_width-1:0] gnt_idx_o,
    output logic                   gnt_valid_o
);

    localparam int c_n = int'(g_num_req);

    logic [g_idx_width-1:0] ptr_q;
    int                     pos;

    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        pos         = 0;
        for (int off = 1; off <= c_n; off++) begin
            pos = int'(ptr_q) + off;
            if (pos >= c_n) begin
                pos = pos - c_n;
            end
            for (int k = 0; k < c_n; k++) begin
                if (!gnt_valid_o && pos == k && req_i[k]) begin
                    gnt_o[k]    = 1'b1;
                    gnt_idx_o   = g_idx_width'(k);
                    gnt_valid_o = 1'b1;
                end
            end
        end
    end

    // Pointer starts at the last channel so channel 0 wins first after reset.
    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= g_idx_width'(g_num_req - 1);
        end else if (en_i && gnt_valid_o) begin
            ptr_q <= gnt_idx_o;
        end
    end

endmodule

// File: rtl/trigger_tx_arbiter.sv
// Holds one pending trigger per channel and feeds them round-robin to the TX framer.
module trigger_tx_arbiter
    import trigger_dist_pkg::*;
#(
    parameter int unsigned g_num_channels = 4,
    parameter int unsigned g_id_width     = 16
) (
    input  logic                                       clk_sys_i,
    input  logic                                       rst_i,
    input  logic [g_num_channels-1:0]                  ch_enable_i,
    input  logic [g_num_channels-1:0]                  ch_stb_i,
    input  logic [g_num_channels*g_id_width-1:0]       ch_id_i,
    input  logic [g_num_channels*40-1:0]               ch_tai_i,
    input  logic [g_num_channels*28-1:0]               ch_cycles_i,
    input  logic [g_num_channels*12-1:0]               ch_frac_i,
    input  logic [c_trig_holdoff_width-1:0]            cfg_holdoff_i,
    input  logic                                       drop_clr_i,
    output logic [g_num_channels*c_drop_cnt_width-1:0] drop_cnt_o,
    output logic                                       tx_valid_o,
    input  logic                                       tx_ready_i,
    output logic [c_ch_idx_width-1:0]                  tx_ch_o,
    output logic [g_id_width-1:0]                      tx_id_o,
    output logic [39:0]                                tx_tai_o,
    output logic [27:0]                                tx_cycles_o,
    output logic [11:0]                                tx_frac_o
);

    localparam int N = int'(g_num_channels);
    localparam int W = int'(g_id_width);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StOffer   = 2'd1;
    localparam logic [1:0] StHoldoff = 2'd2;

    logic [N-1:0]                      full_q, full_d;
    logic [N-1:0]                      req, gnt, freed, capture, drop;
    logic [W-1:0]                      slot_id_q [N];
    t_trig_ts                          slot_ts_q [N];
    logic [c_drop_cnt_width-1:0]       drop_q    [N];
    logic [W-1:0]                      in_id     [N];
    t_trig_ts                          in_ts     [N];

    logic [1:0]                        state_q, state_d;
    logic [c_trig_holdoff_width-1:0]   hold_cnt_q, hold_cnt_d;
    logic                              tx_valid_q;
    logic [c_ch_idx_width-1:0]         tx_ch_q;
    logic [W-1:0]                      tx_id_q;
    t_trig_ts                          tx_ts_q;

    logic                              handshake, arb_en, grant, gnt_valid;
    logic [c_ch_idx_width-1:0]         gnt_idx;
    logic [W-1:0]                      sel_id;
    t_trig_ts                          sel_ts;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            in_id[k]        = ch_id_i[k*W +: W];
            in_ts[k].tai    = ch_tai_i[k*40 +: 40];
            in_ts[k].cycles = ch_cycles_i[k*28 +: 28];
            in_ts[k].frac   = ch_frac_i[k*12 +: 12];
        end
    end

    assign handshake = tx_valid_q & tx_ready_i;

    // A slot freed by this cycle's handshake may take a new strobe without a drop.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            freed[k]   = handshake && (tx_ch_q == c_ch_idx_width'(k));
            capture[k] = ch_stb_i[k] & ch_enable_i[k] & (~full_q[k] | freed[k]);
            drop[k]    = ch_stb_i[k] & ch_enable_i[k] & full_q[k] & ~freed[k];
            full_d[k]  = capture[k] | (full_q[k] & ~freed[k] & ch_enable_i[k]);
        end
    end

    assign req    = full_q & ch_enable_i;
    assign arb_en = (state_q == StIdle) ||
                    (state_q == StHoldoff && hold_cnt_q == c_trig_holdoff_width'(1));
    assign grant  = arb_en & gnt_valid;

    rr_arbiter_core #(
        .g_num_req   (g_num_channels),
        .g_idx_width (c_ch_idx_width)
    ) u_rr_arbiter_core (
        .clk_sys_i   (clk_sys_i),
        .rst_i       (rst_i),
        .req_i       (req),
        .en_i        (arb_en),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    always_comb begin
        sel_id = '0;
        sel_ts = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt[k]) begin
                sel_id = slot_id_q[k];
                sel_ts = slot_ts_q[k];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StOffer;
                end
            end
            StOffer: begin
                if (handshake) begin
                    if (cfg_holdoff_i == '0) begin
                        state_d = StIdle;
                    end else begin
                        hold_cnt_d = cfg_holdoff_i;
                        state_d    = StHoldoff;
                    end
                end
            end
            StHoldoff: begin
                // The last holdoff cycle arbitrates directly so the gap is exactly H+1.
                if (hold_cnt_q == c_trig_holdoff_width'(1)) begin
                    state_d = grant ? StOffer : StIdle;
                end else begin
                    hold_cnt_d = hold_cnt_q - c_trig_holdoff_width'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            hold_cnt_q <= '0;
            tx_valid_q <= 1'b0;
            tx_ch_q    <= '0;
            tx_id_q    <= '0;
            tx_ts_q    <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            if (grant) begin
                tx_valid_q <= 1'b1;
                tx_ch_q    <= gnt_idx;
                tx_id_q    <= sel_id;
                tx_ts_q    <= sel_ts;
            end else if (handshake) begin
                tx_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= '0;
            for (int k = 0; k < N; k++) begin
                slot_id_q[k] <= '0;
                slot_ts_q[k] <= '0;
                drop_q[k]    <= '0;
            end
        end else begin
            full_q <= full_d;
            for (int k = 0; k < N; k++) begin
                if (capture[k]) begin
                    slot_id_q[k] <= in_id[k];
                    slot_ts_q[k] <= in_ts[k];
                end
                if (drop_clr_i) begin
                    drop_q[k] <= '0;
                end else if (drop[k] && drop_q[k] != '1) begin
                    drop_q[k] <= drop_q[k] + c_drop_cnt_width'(1);
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            drop_cnt_o[k*c_drop_cnt_width +: c_drop_cnt_width] = drop_q[k];
        end
    end

    assign tx_valid_o  = tx_valid_q;
    assign tx_ch_o     = tx_ch_q;
    assign tx_id_o     = tx_id_q;
    assign tx_tai_o    = tx_ts_q.tai;
    assign tx_cycles_o = tx_ts_q.cycles;
    assign tx_frac_o   = tx_ts_q.frac;

endmodule

// File: tb/tb_trigger_tx_arbiter.sv
// Directed self-checking bench for trigger_tx_arbiter.
module tb_trigger_tx_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk_sys = 1'b0;
    logic           rst;
    logic [N-1:0]   ch_enable;
    logic [N-1:0]   ch_stb;
    logic [N*W-1:0] ch_id;
    logic [N*40-1:0] ch_tai;
    logic [N*28-1:0] ch_cycles;
    logic [N*12-1:0] ch_frac;
    logic [15:0]    cfg_holdoff;
    logic           drop_clr;
    logic [N*16-1:0] drop_cnt;
    logic           tx_valid;
    logic           tx_ready;
    logic [2:0]     tx_ch;
    logic [W-1:0]   tx_id;
    logic [39:0]    tx_tai;
    logic [27:0]    tx_cycles;
    logic [11:0]    tx_frac;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_sys = ~clk_sys;

    trigger_tx_arbiter #(
        .g_num_channels (N),
        .g_id_width     (W)
    ) dut (
        .clk_sys_i     (clk_sys),
        .rst_i         (rst),
        .ch_enable_i   (ch_enable),
        .ch_stb_i      (ch_stb),
        .ch_id_i       (ch_id),
        .ch_tai_i      (ch_tai),
        .ch_cycles_i   (ch_cycles),
        .ch_frac_i     (ch_frac),
        .cfg_holdoff_i (cfg_holdoff),
        .drop_clr_i    (drop_clr),
        .drop_cnt_o    (drop_cnt),
        .tx_valid_o    (tx_valid),
        .tx_ready_i    (tx_ready),
        .tx_ch_o       (tx_ch),
        .tx_id_o       (tx_id),
        .tx_tai_o      (tx_tai),
        .tx_cycles_o   (tx_cycles),
        .tx_frac_o     (tx_frac)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic stb(input int k, input logic [15:0] id, input logic [39:0] tai,
                       input logic [27:0] cyc, input logic [11:0] frac);
        ch_stb[k]            = 1'b1;
        ch_id[k*W +: W]      = id;
        ch_tai[k*40 +: 40]   = tai;
        ch_cycles[k*28 +: 28] = cyc;
        ch_frac[k*12 +: 12]  = frac;
    endtask

    function automatic logic [15:0] drop_of(input int k);
        return drop_cnt[k*16 +: 16];
    endfunction

    task automatic do_reset();
        rst         = 1'b1;
        ch_stb      = '0;
        ch_enable   = '1;
        tx_ready    = 1'b0;
        drop_clr    = 1'b0;
        cfg_holdoff = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        ch_id     = '0;
        ch_tai    = '0;
        ch_cycles = '0;
        ch_frac   = '0;
        rst       = 1'b1;
        ch_stb    = '0;
        ch_enable = '1;
        tx_ready  = 1'b0;
        drop_clr  = 1'b0;
        cfg_holdoff = '0;
        tick();
        check("rst_valid", tx_valid, 0);
        check("rst_ch", tx_ch, 0);
        check("rst_id", tx_id, 0);
        check("rst_tai", tx_tai, 0);
        check("rst_drop", drop_cnt, 0);

        // Single trigger on channel 2
        do_reset();
        tx_ready = 1'b1;
        stb(2, 16'h000B, 40'd5, 28'd1000, 12'h123);
        tick();
        ch_stb = '0;
        check("single_t1_valid", tx_valid, 0);
        tick();
        check("single_t2_valid", tx_valid, 1);
        check("single_ch", tx_ch, 2);
        check("single_id", tx_id, 16'h000B);
        check("single_tai", tx_tai, 5);
        check("single_cycles", tx_cycles, 1000);
        check("single_frac", tx_frac, 12'h123);
        tick();
        check("single_t3_valid", tx_valid, 0);

        // Round-robin fairness
        do_reset();
        tx_ready = 1'b1;
        for (int k = 0; k < N; k++) stb(k, 16'h0010 + 16'(k), 40'(k), 28'(k), 12'(k));
        tick();
        ch_stb = '0;
        check("rr_t1_valid", tx_valid, 0);
        tick();
        for (int g = 0; g < N; g++) begin
            check("rr_valid", tx_valid, 1);
            check("rr_ch", tx_ch, 3'(g));
            check("rr_id", tx_id, 16'h0010 + 16'(g));
            tick();
            check("rr_gap", tx_valid, 0);
            if (g < N - 1) tick();
        end
        stb(0, 16'h0020, 40'd0, 28'd0, 12'd0);
        stb(3, 16'h0023, 40'd0, 28'd0, 12'd0);
        tick();
        ch_stb = '0;
        check("rr2_t1_valid", tx_valid, 0);
        tick();
        check("rr2_first_ch", tx_ch, 0);
        check("rr2_first_id", tx_id, 16'h0020);
        tick();
        check("rr2_gap", tx_valid, 0);
        tick();
        check("rr2_second_valid", tx_valid, 1);
        check("rr2_second_ch", tx_ch, 3);
        check("rr2_second_id", tx_id, 16'h0023);

        // Backpressure and overflow on channel 1
        do_reset();
        stb(1, 16'h00A1, 40'd1, 28'd1, 12'd1);
        tick();
        ch_stb = '0;
        tick();
        check("bp_valid", tx_valid, 1);
        stb(1, 16'h00A2, 40'd2, 28'd2, 12'd2);
        tick();
        ch_stb = '0;
        check("bp_drop1", drop_of(1), 1);
        check("bp_hold_id", tx_id, 16'h00A1);
        tick();
        stb(1, 16'h00A3, 40'd3, 28'd3, 12'd3);
        tick();
        ch_stb = '0;
        check("bp_drop2", drop_of(1), 2);
        check("bp_hold_valid", tx_valid, 1);
        check("bp_hold_id2", tx_id, 16'h00A1);
        check("bp_hold_tai", tx_tai, 1);
        tx_ready = 1'b1;
        tick();
        check("bp_after_hs", tx_valid, 0);
        tick();
        check("bp_one_frame_a", tx_valid, 0);
        tick();
        check("bp_one_frame_b", tx_valid, 0);
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        check("bp_drop_clr", drop_of(1), 0);

        // Holdoff of 10 cycles
        do_reset();
        tx_ready    = 1'b1;
        cfg_holdoff = 16'd10;
        stb(0, 16'h0B00, 40'd0, 28'd0, 12'd0);
        stb(1, 16'h0B01, 40'd0, 28'd0, 12'd0);
        tick();
        ch_stb = '0;
        tick();
        check("ho_first_valid", tx_valid, 1);
        check("ho_first_ch", tx_ch, 0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            check("ho_quiet", tx_valid, 0);
        end
        tick();
        check("ho_second_valid", tx_valid, 1);
        check("ho_second_ch", tx_ch, 1);

        // Same-cycle free and capture on channel 0
        do_reset();
        tx_ready = 1'b1;
        stb(0, 16'h0100, 40'd7, 28'd7, 12'd7);
        tick();
        ch_stb = '0;
        tick();
        check("sc_first_id", tx_id, 16'h0100);
        stb(0, 16'h0200, 40'd8, 28'd8, 12'd8);
        tick();
        ch_stb = '0;
        check("sc_gap", tx_valid, 0);
        check("sc_no_drop", drop_of(0), 0);
        tick();
        check("sc_second_valid", tx_valid, 1);
        check("sc_second_ch", tx_ch, 0);
        check("sc_second_id", tx_id, 16'h0200);
        check("sc_second_tai", tx_tai, 8);

        // Disable flushes a pending, ungranted slot
        do_reset();
        stb(0, 16'h0070, 40'd0, 28'd0, 12'd0);
        stb(3, 16'h0073, 40'd0, 28'd0, 12'd0);
        tick();
        ch_stb = '0;
        tick();
        check("dis_offer_ch", tx_ch, 0);
        ch_enable[3] = 1'b0;
        tick();
        ch_enable[3] = 1'b1;
        tick();
        tx_ready = 1'b1;
        tick();
        check("dis_after_hs", tx_valid, 0);
        ch_enable[2] = 1'b0;
        stb(2, 16'h0072, 40'd0, 28'd0, 12'd0);
        tick();
        ch_stb = '0;
        ch_enable[2] = 1'b1;
        check("dis_flushed_a", tx_valid, 0);
        tick();
        check("dis_flushed_b", tx_valid, 0);
        check("dis_ign_drop", drop_of(2), 0);

        // Reset during OFFER
        do_reset();
        stb(1, 16'h0055, 40'd0, 28'd0, 12'd0);
        tick();
        ch_stb = '0;
        tick();
        check("rof_offer", tx_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rof_async_valid", tx_valid, 0);
        check("rof_async_id", tx_id, 0);
        tick();
        rst = 1'b0;
        check("rof_no_drop", drop_of(1), 0);
        tx_ready = 1'b1;
        stb(1, 16'h0066, 40'd9, 28'd9, 12'd9);
        tick();
        ch_stb = '0;
        check("rof_t1_valid", tx_valid, 0);
        tick();
        check("rof_regrant_valid", tx_valid, 1);
        check("rof_regrant_ch", tx_ch, 1);
        check("rof_regrant_id", tx_id, 16'h0066);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
